int_writeback: RTL and testbench

INT_WRITEBACK -- requirements
Module: int_writeback

---
 rtl/int_writeback_if.sv | 70 +++++++
 rtl/int_writeback.sv | 221 ++++++++++++++++++++++
 tb/tb_int_writeback.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/int_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_writeback_if
//  Description : Bundle of the signals between the integer writeback block
//                and its neighbours.
//                Issue side   : issue_valid/rd/rs1/rs2/addr/is_muldiv in,
//                               issue_stall out.
//                Execute side : exec_int_output_valid, exec_int_exception,
//                               exec_int_trap_cause, exec_int_result in.
//                Trap control : flush in; trap_valid/cause/addr out.
//                Regfile      : reg_write_en/sel/data out.
//                The "slave" modport is the writeback block. The "master"
//                modport is its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface int_writeback_if #(
  parameter int XLEN = 64,
  parameter int ALEN = 64
);
  // issue port
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic [ALEN-1:0] issue_addr;
  logic            issue_is_muldiv;
  logic            issue_stall;

  // execute result port
  logic            exec_int_output_valid;
  logic            exec_int_exception;
  logic [3:0]      exec_int_trap_cause;
  logic [XLEN-1:0] exec_int_result;

  // trap controller
  logic            flush;

  // register file write port
  logic            reg_write_en;
  logic [4:0]      reg_write_sel;
  logic [XLEN-1:0] reg_write_data;

  // trap pulse
  logic            trap_valid;
  logic [3:0]      trap_cause;
  logic [ALEN-1:0] trap_addr;

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2, issue_addr,
           issue_is_muldiv,
    input  exec_int_output_valid, exec_int_exception, exec_int_trap_cause,
           exec_int_result,
    input  flush,
    output issue_stall,
    output reg_write_en, reg_write_sel, reg_write_data,
    output trap_valid, trap_cause, trap_addr
  );

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2, issue_addr,
           issue_is_muldiv,
    output exec_int_output_valid, exec_int_exception, exec_int_trap_cause,
           exec_int_result,
    output flush,
    input  issue_stall,
    input  reg_write_en, reg_write_sel, reg_write_data,
    input  trap_valid, trap_cause, trap_addr
  );
endinterface
`default_nettype wire

// File: rtl/int_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : int_writeback
//  Description : Integer-pipe writeback and hazard control. It tracks in-flight
//                instructions with two tag stages (T1 for every op, T2 for the
//                second cycle of a mul/div op). It matches execute results to
//                their tag and writes the register file one cycle later. It
//                keeps a pending-destination scoreboard to stall RAW/WAW
//                hazards. It converts an exception result into a one-cycle
//                trap pulse and then squashes until the trap controller
//                flushes.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                wb        - int_writeback_if.slave (issue, execute result,
//                            flush, regfile write and trap pulse signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module int_writeback #(
  parameter int XLEN = 64,
  parameter int ALEN = 64
) (
  input  wire logic         clk,
  input  wire logic         rst,
  int_writeback_if.slave    wb
);

  // --------------------------------------------------------------------------
  // Control state: RUN accepts results; SQUASH discards everything until flush.
  // --------------------------------------------------------------------------
  localparam logic [0:0] c_st_run    = 1'b0;
  localparam logic [0:0] c_st_squash = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic            w_squash;

  // tag stages
  logic            r_t1_valid;
  logic [4:0]      r_t1_rd;
  logic [ALEN-1:0] r_t1_addr;
  logic            r_t1_muldiv;
  logic            r_t2_valid;
  logic [4:0]      r_t2_rd;
  logic [ALEN-1:0] r_t2_addr;

  // scoreboard
  logic [31:0]     r_pending;
  logic [31:0]     w_pending_next;

  // result ownership and decisions
  logic            w_own_valid;
  logic [4:0]      w_own_rd;
  logic [ALEN-1:0] w_own_addr;
  logic            w_result_owned;
  logic            w_result_live;
  logic            w_exc_take;
  logic            w_write_take;
  logic            w_result_drop;

  // issue control
  logic            w_stall;
  logic            w_issue_accept;

  // registered outputs
  logic            r_reg_write_en;
  logic [4:0]      r_reg_write_sel;
  logic [XLEN-1:0] r_reg_write_data;
  logic            r_trap_valid;
  logic [3:0]      r_trap_cause;
  logic [ALEN-1:0] r_trap_addr;

  // --------------------------------------------------------------------------
  // Issue stall. The execute unit holds one mul/div at a time, so the cycle
  // right after a mul/div is accepted (T1 holds it) is blocked. Bit 0 of the
  // scoreboard is never set, so x0 sources never stall.
  // --------------------------------------------------------------------------
  assign w_stall = wb.flush
                 | w_squash
                 | (r_t1_valid & r_t1_muldiv)
                 | r_pending[wb.issue_rs1]
                 | r_pending[wb.issue_rs2]
                 | r_pending[wb.issue_rd];

  assign w_issue_accept = wb.issue_valid & ~w_stall;

  // --------------------------------------------------------------------------
  // Result ownership. T2 (the mul/div in its second cycle) has priority. A
  // mul/div sitting in T1 is not yet due, so it cannot own a result.
  // --------------------------------------------------------------------------
  always_comb begin
    w_own_valid = 1'b0;
    w_own_rd    = r_t1_rd;
    w_own_addr  = r_t1_addr;
    if (r_t2_valid) begin
      w_own_valid = 1'b1;
      w_own_rd    = r_t2_rd;
      w_own_addr  = r_t2_addr;
    end else if (r_t1_valid && !r_t1_muldiv) begin
      w_own_valid = 1'b1;
    end
  end

  assign w_result_owned = wb.exec_int_output_valid & w_own_valid;
  // A result is acted on only outside SQUASH and outside a flush cycle.
  assign w_result_live  = w_result_owned & ~w_squash & ~wb.flush;
  assign w_exc_take     = w_result_live & wb.exec_int_exception;
  assign w_write_take   = w_result_live & ~wb.exec_int_exception
                        & (w_own_rd != 5'd0);
  // Owned results that never reach the regfile still release their
  // destination. Otherwise the scoreboard entry would stick until a flush.
  assign w_result_drop  = w_result_owned & (w_squash | wb.exec_int_exception);

  // --------------------------------------------------------------------------
  // Scoreboard next state. A destination is released on the edge that ends
  // the reg_write_en cycle. Consumers see the value through the regfile
  // afterwards, so no bypass is needed. A new issue to the same register
  // takes priority over the release.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pending_next = r_pending;
    if (r_reg_write_en) begin
      w_pending_next[r_reg_write_sel] = 1'b0;
    end
    if (w_result_drop) begin
      w_pending_next[w_own_rd] = 1'b0;
    end
    if (w_issue_accept && (wb.issue_rd != 5'd0)) begin
      w_pending_next[wb.issue_rd] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. A flush always returns to RUN. This also covers a flush
  // that arrives in the same cycle as an exception.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_run: begin
        if (w_exc_take) begin
          w_state_next = c_st_squash;
        end
      end
      c_st_squash: begin
        w_state_next = c_st_squash;
      end
      default: begin
        w_state_next = c_st_run;
      end
    endcase
    if (wb.flush) begin
      w_state_next = c_st_run;
    end
  end

  // FSM: outputs
  always_comb begin
    w_squash = 1'b0;
    if (r_state == c_st_squash) begin
      w_squash = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers: valids, strobes and the scoreboard
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t1_valid     <= 1'b0;
      r_t2_valid     <= 1'b0;
      r_pending      <= 32'd0;
      r_reg_write_en <= 1'b0;
      r_trap_valid   <= 1'b0;
    end else begin
      // w_issue_accept is already low during a flush, so T1 clears then.
      r_t1_valid     <= w_issue_accept;
      r_t2_valid     <= r_t1_valid & r_t1_muldiv & ~wb.flush;
      r_pending      <= wb.flush ? 32'd0 : w_pending_next;
      r_reg_write_en <= w_write_take;
      r_trap_valid   <= w_exc_take;
    end
  end

  // --------------------------------------------------------------------------
  // Payload registers. These are qualified by the valids and strobes above,
  // so they load every cycle without a reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    r_t1_rd          <= wb.issue_rd;
    r_t1_addr        <= wb.issue_addr;
    r_t1_muldiv      <= wb.issue_is_muldiv;
    r_t2_rd          <= r_t1_rd;
    r_t2_addr        <= r_t1_addr;
    r_reg_write_sel  <= w_own_rd;
    r_reg_write_data <= wb.exec_int_result;
    r_trap_cause     <= wb.exec_int_trap_cause;
    r_trap_addr      <= w_own_addr;
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign wb.issue_stall    = w_stall;
  assign wb.reg_write_en   = r_reg_write_en;
  assign wb.reg_write_sel  = r_reg_write_sel;
  assign wb.reg_write_data = r_reg_write_data;
  assign wb.trap_valid     = r_trap_valid;
  assign wb.trap_cause     = r_trap_cause;
  assign wb.trap_addr      = r_trap_addr;

endmodule
`default_nettype wire

// File: tb/tb_int_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_writeback
//  Description : Directed testbench for int_writeback. The stimulus pushes
//                expected regfile writes and trap pulses, each with the cycle
//                it is due, into a queue. A negedge monitor pops and compares
//                every strobe the DUT raises. The stimulus also checks
//                issue_stall directly against constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_writeback;

  localparam int XLEN = 64;
  localparam int ALEN = 64;

  typedef struct {
    bit          is_trap;
    int          cyc;
    logic [4:0]  sel;
    logic [63:0] data;
    logic [3:0]  cause;
    logic [63:0] addr;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;
  exp_t q[$];

  int_writeback_if #(.XLEN(XLEN), .ALEN(ALEN)) wb ();

  int_writeback #(.XLEN(XLEN), .ALEN(ALEN)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic exp_t wr(input int c, input logic [4:0] s, input logic [63:0] d);
    exp_t e;
    e.is_trap = 1'b0; e.cyc = c; e.sel = s; e.data = d; e.cause = 4'd0; e.addr = 64'd0;
    return e;
  endfunction

  function automatic exp_t tr(input int c, input logic [3:0] ca, input logic [63:0] a);
    exp_t e;
    e.is_trap = 1'b1; e.cyc = c; e.sel = 5'd0; e.data = 64'd0; e.cause = ca; e.addr = a;
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (wb.reg_write_en === 1'b1 && wb.trap_valid === 1'b1)
      check(1'b0, "strobe_overlap", $sformatf("cyc=%0d both reg_write_en and trap_valid high, required exclusive", cyc));
    if (wb.reg_write_en === 1'b1) begin
      if (q.size() == 0) begin
        check(1'b0, "reg_write", $sformatf("unexpected write cyc=%0d sel=%0d data=%h, required none", cyc, wb.reg_write_sel, wb.reg_write_data));
      end else begin
        e = q.pop_front();
        check(!e.is_trap && e.cyc == cyc && e.sel == wb.reg_write_sel && e.data == wb.reg_write_data,
              "reg_write",
              $sformatf("got write cyc=%0d sel=%0d data=%h, required %s cyc=%0d sel=%0d data=%h",
                        cyc, wb.reg_write_sel, wb.reg_write_data, e.is_trap ? "trap" : "write", e.cyc, e.sel, e.data));
      end
    end
    if (wb.trap_valid === 1'b1) begin
      if (q.size() == 0) begin
        check(1'b0, "trap", $sformatf("unexpected trap cyc=%0d cause=%0d addr=%h, required none", cyc, wb.trap_cause, wb.trap_addr));
      end else begin
        e = q.pop_front();
        check(e.is_trap && e.cyc == cyc && e.cause == wb.trap_cause && e.addr == wb.trap_addr,
              "trap",
              $sformatf("got trap cyc=%0d cause=%0d addr=%h, required %s cyc=%0d cause=%0d addr=%h",
                        cyc, wb.trap_cause, wb.trap_addr, e.is_trap ? "trap" : "write", e.cyc, e.cause, e.addr));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wb.issue_valid           = 1'b0;
    wb.issue_rd              = 5'd0;
    wb.issue_rs1             = 5'd0;
    wb.issue_rs2             = 5'd0;
    wb.issue_addr            = '0;
    wb.issue_is_muldiv       = 1'b0;
    wb.exec_int_output_valid = 1'b0;
    wb.exec_int_exception    = 1'b0;
    wb.exec_int_trap_cause   = 4'd0;
    wb.exec_int_result       = '0;
    wb.flush                 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [63:0] addr, input logic md);
    wb.issue_valid     = 1'b1;
    wb.issue_rd        = rd;
    wb.issue_rs1       = rs1;
    wb.issue_rs2       = rs2;
    wb.issue_addr      = addr;
    wb.issue_is_muldiv = md;
  endtask

  task automatic result(input logic [63:0] d, input logic exc, input logic [3:0] cause);
    wb.exec_int_output_valid = 1'b1;
    wb.exec_int_exception    = exc;
    wb.exec_int_trap_cause   = cause;
    wb.exec_int_result       = d;
  endtask

  task automatic chk_stall(input logic exp, input string name);
    #1;
    check(wb.issue_stall === exp, name,
          $sformatf("cyc=%0d issue_stall=%b, required %b", cyc, wb.issue_stall, exp));
  endtask

  // ---------------- sequence ----------------
  initial begin
    int t;
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check(wb.reg_write_en === 1'b0, "reset_write_en", $sformatf("reg_write_en=%b, required 0", wb.reg_write_en));
    check(wb.trap_valid === 1'b0, "reset_trap_valid", $sformatf("trap_valid=%b, required 0", wb.trap_valid));
    rst = 1'b0;
    step();
    chk_stall(1'b0, "reset_stall");

    // ADDI x5 = 0x2A, then a consumer of x5
    t = cyc; issue(5'd5, 5'd1, 5'd2, 64'h100, 1'b0); chk_stall(1'b0, "addi_accept");
    q.push_back(wr(t + 2, 5'd5, 64'h2A)); step();
    result(64'h2A, 1'b0, 4'd0); step();
    issue(5'd6, 5'd5, 5'd0, 64'h104, 1'b0); chk_stall(1'b1, "x5_pending_t2"); step();
    t = cyc; issue(5'd6, 5'd5, 5'd0, 64'h104, 1'b0); chk_stall(1'b0, "x5_clear_t3");
    q.push_back(wr(t + 2, 5'd6, 64'h11)); step();
    result(64'h11, 1'b0, 4'd0); step(); step();

    // MUL x7 = 0x64: busy stall, 2-cycle execute
    t = cyc; issue(5'd7, 5'd1, 5'd2, 64'h200, 1'b1); chk_stall(1'b0, "mul_accept"); step();
    chk_stall(1'b1, "mul_busy"); step();
    result(64'h64, 1'b0, 4'd0); q.push_back(wr(t + 3, 5'd7, 64'h64)); step();
    step(); step();

    // RAW on x3: stall t+1, t+2, accepted t+3
    t = cyc; issue(5'd3, 5'd1, 5'd2, 64'h300, 1'b0); chk_stall(1'b0, "x3_accept");
    q.push_back(wr(t + 2, 5'd3, 64'h33)); step();
    issue(5'd4, 5'd3, 5'd0, 64'h304, 1'b0); result(64'h33, 1'b0, 4'd0); chk_stall(1'b1, "raw_x3_t1"); step();
    issue(5'd4, 5'd3, 5'd0, 64'h304, 1'b0); chk_stall(1'b1, "raw_x3_t2"); step();
    issue(5'd4, 5'd3, 5'd0, 64'h304, 1'b0); chk_stall(1'b0, "raw_x3_t3");
    q.push_back(wr(t + 5, 5'd4, 64'h44)); step();
    result(64'h44, 1'b0, 4'd0); step(); step(); step();

    // write to x0 is dropped and never stalls
    issue(5'd0, 5'd1, 5'd2, 64'h400, 1'b0); chk_stall(1'b0, "x0_accept"); step();
    t = cyc; result(64'hFF, 1'b0, 4'd0); issue(5'd9, 5'd0, 5'd0, 64'h404, 1'b0); chk_stall(1'b0, "x0_no_stall");
    q.push_back(wr(t + 2, 5'd9, 64'h99)); step();
    result(64'h99, 1'b0, 4'd0); step(); step(); step();

    // illegal op, trailing ADDI x4 squashed, stall until flush
    t = cyc; issue(5'd12, 5'd1, 5'd2, 64'h1000, 1'b0); chk_stall(1'b0, "illegal_accept"); step();
    result(64'h0, 1'b1, 4'd2); issue(5'd4, 5'd1, 5'd0, 64'h1004, 1'b0); chk_stall(1'b0, "addi4_accept");
    q.push_back(tr(t + 2, 4'd2, 64'h1000)); step();
    result(64'h4444, 1'b0, 4'd0); chk_stall(1'b1, "squash_stall_a"); step();
    issue(5'd13, 5'd0, 5'd0, 64'h1008, 1'b0); result(64'h0, 1'b1, 4'd5); chk_stall(1'b1, "squash_stall_b"); step();
    wb.flush = 1'b1; issue(5'd13, 5'd0, 5'd0, 64'h1008, 1'b0); chk_stall(1'b1, "flush_stall"); step();
    t = cyc; issue(5'd14, 5'd4, 5'd12, 64'h100C, 1'b0); chk_stall(1'b0, "post_flush_accept");
    q.push_back(wr(t + 2, 5'd14, 64'h1414)); step();
    result(64'h1414, 1'b0, 4'd0); step(); step(); step();

    // flush and exception together: no trap, no squash
    issue(5'd15, 5'd1, 5'd2, 64'h2000, 1'b0); chk_stall(1'b0, "fx_accept"); step();
    result(64'h0, 1'b1, 4'd3); wb.flush = 1'b1; step();
    t = cyc; issue(5'd16, 5'd15, 5'd0, 64'h2004, 1'b0); chk_stall(1'b0, "fx_no_squash");
    q.push_back(wr(t + 2, 5'd16, 64'h1616)); step();
    result(64'h1616, 1'b0, 4'd0); step(); step(); step();

    // reset one cycle after MUL issue: late result ignored
    issue(5'd7, 5'd1, 5'd2, 64'h3000, 1'b1); chk_stall(1'b0, "rst_mul_accept"); step();
    rst = 1'b1; step();
    rst = 1'b0; result(64'h77, 1'b0, 4'd0);
    wb.issue_rd = 5'd7; wb.issue_rs1 = 5'd7; wb.issue_rs2 = 5'd7; chk_stall(1'b0, "rst_scoreboard_clear");
    step(); step(); step(); step();

    check(q.size() == 0, "scoreboard_drain", $sformatf("%0d expected events outstanding, required 0", q.size()));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
